// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: a prescaled game tick drives gap/mole/game timers,
// pops one-hot moles from the RNG index, and scores hits and expired moles.
module mole_scheduler #(
  parameter int TICK_DIV   = 50000000,
  parameter int GAP_TICKS  = 1,
  parameter int MOLE_TICKS = 2,
  parameter int GAME_TICKS = 30,
  parameter int MAX_MISS   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hit_btn,
  input  logic [1:0] rand_sel,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic [7:0] time_left,
  output logic       mole_event,
  output logic       game_over
);
  // state | meaning
  // IDLE  | power-up, waiting for start
  // GAP   | no mole shown, counting gap ticks
  // UP    | mole shown, waiting for a hit or expiry
  // DONE  | game finished, results held until start
  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LD   = 8'(GAP_TICKS);
  localparam logic [7:0]    MOLE_LD  = 8'(MOLE_TICKS);
  localparam logic [7:0]    GAME_LD  = 8'(GAME_TICKS);
  localparam logic [3:0]    MISS_LIM = 4'(MAX_MISS);

  state_t        state;
  logic [PW-1:0] pre;
  logic [7:0]    gap_cnt;
  logic [7:0]    mole_cnt;
  logic [3:0]    hit_btn_q;

  logic       in_play;
  logic       tick;
  logic       hit_match;
  logic       mole_exp;
  logic       miss_now;
  logic [3:0] misses_inc;
  logic       game_end;

  always_comb begin
    in_play    = (state == GAP) || (state == UP);
    tick       = in_play && (pre == PRE_MAX);
    hit_match  = (state == UP) && ((hit_btn & ~hit_btn_q & mole) != 4'b0000);
    mole_exp   = (state == UP) && tick && (mole_cnt == 8'd1);
    // a matching hit on the expiry cycle wins over the miss
    miss_now   = mole_exp && !hit_match;
    misses_inc = misses + 4'd1;
    game_end   = (tick && (time_left == 8'd1)) || (miss_now && (misses_inc == MISS_LIM));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pre        <= '0;
      gap_cnt    <= 8'd0;
      mole_cnt   <= 8'd0;
      hit_btn_q  <= 4'b0000;
      mole       <= 4'b0000;
      score      <= 8'd0;
      misses     <= 4'd0;
      time_left  <= 8'd0;
      mole_event <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      hit_btn_q  <= hit_btn;
      mole_event <= 1'b0;
      if (in_play) pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
      if (tick) time_left <= time_left - 8'd1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= GAP;
            pre       <= '0;
            score     <= 8'd0;
            misses    <= 4'd0;
            time_left <= GAME_LD;
            gap_cnt   <= GAP_LD;
            mole      <= 4'b0000;
            game_over <= 1'b0;
          end
        end

        GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt - 8'd1;
            if (game_end) begin
              state     <= DONE;
              pre       <= '0;
              game_over <= 1'b1;
            end else if (gap_cnt == 8'd1) begin
              state      <= UP;
              pre        <= '0;
              mole       <= 4'b0001 << rand_sel;
              mole_cnt   <= MOLE_LD;
              mole_event <= 1'b1;
            end
          end
        end

        UP: begin
          if (tick) mole_cnt <= mole_cnt - 8'd1;
          // an expiry still counts as a miss even when it ends the game
          if (miss_now) begin
            misses     <= misses_inc;
            mole_event <= 1'b1;
          end
          if (game_end) begin
            state     <= DONE;
            pre       <= '0;
            mole      <= 4'b0000;
            game_over <= 1'b1;
          end else if (hit_match) begin
            state      <= GAP;
            pre        <= '0;
            score      <= (score == 8'hFF) ? score : score + 8'd1;
            mole       <= 4'b0000;
            mole_event <= 1'b1;
            gap_cnt    <= GAP_LD;
          end else if (miss_now) begin
            state   <= GAP;
            pre     <= '0;
            mole    <= 4'b0000;
            gap_cnt <= GAP_LD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
